// File: rtl/instruction_encoder_writer.sv
// instruction_encoder_writer
// Packs MIPS R/I/J instruction fields into 32-bit words, buffers them in a
// small FIFO and streams them to instruction memory at an auto-incrementing
// word address.
// Optional feature macro: ENCODER_ERR_EN
//   defined   : fmt=11 bundles are accepted but dropped, err is sticky.
//   undefined : fmt=11 bundles are written as NOP (32'h0), err tied low.
module instruction_encoder_writer #(
    parameter int ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            fmt,
    input  logic [5:0]            op,
    input  logic [4:0]            rs,
    input  logic [4:0]            rt,
    input  logic [4:0]            rd,
    input  logic [4:0]            shamt,
    input  logic [5:0]            funct,
    input  logic [15:0]           imm_16,
    input  logic [25:0]           address_26,
    input  logic                  base_load,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  mem_we,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [15:0]           count,
    output logic                  err
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [31:0]           fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_idx;
    logic [PW-1:0]         rd_idx;
    logic [PW:0]           occ;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [15:0]           done_cnt;
    logic [31:0]           word;
    logic                  full;
    logic                  empty;
    logic                  accept;
    logic                  push;
    logic                  pop;

    assign full     = (occ == (PW+1)'(FIFO_DEPTH));
    assign empty    = (occ == '0);
    assign in_ready = !full && !reset;
    assign accept   = in_valid && in_ready;
    assign pop      = !empty && mem_ready;

`ifdef ENCODER_ERR_EN
    logic err_q;
    assign push = accept && (fmt != 2'b11);
    assign err  = err_q;
`else
    assign push = accept;
    assign err  = 1'b0;
`endif

    // Field packing by instruction format; illegal format packs as NOP.
    always_comb begin
        word = 32'h0000_0000;
        case (fmt)
            2'b00:   word = {op, rs, rt, rd, shamt, funct};
            2'b01:   word = {op, rs, rt, imm_16};
            2'b10:   word = {op, address_26};
            default: word = 32'h0000_0000;
        endcase
    end

    // FIFO storage; contents need no reset since occupancy gates the output.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_idx] <= word;
        end
    end

    // FIFO pointers, write address, completion counter and error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_idx   <= '0;
            rd_idx   <= '0;
            occ      <= '0;
            wr_ptr   <= '0;
            done_cnt <= '0;
`ifdef ENCODER_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            if (push) begin
                wr_idx <= wr_idx + 1'b1;
            end
            if (pop) begin
                rd_idx <= rd_idx + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            // A base reload wins over the increment of a same-edge completion.
            if (base_load) begin
                wr_ptr <= base_addr;
            end else if (pop) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && (done_cnt != 16'hFFFF)) begin
                done_cnt <= done_cnt + 1'b1;
            end
`ifdef ENCODER_ERR_EN
            if (accept && (fmt == 2'b11)) begin
                err_q <= 1'b1;
            end
`endif
        end
    end

    assign mem_we    = !empty;
    assign mem_addr  = wr_ptr;
    assign mem_wdata = empty ? 32'h0000_0000 : fifo_mem[rd_idx];
    assign count     = done_cnt;

endmodule

// File: doc/instruction_encoder_writer.md
# instruction_encoder_writer

Packs MIPS instruction fields (R, I or J format) into 32-bit instruction words and streams them into instruction memory through its write port, at an auto-incrementing word address. It is the write-side counterpart of `instructionDecoder`: a word written here and later decoded returns the original op/rs/rt/rd/imm_16/address_26 fields. It sits between a program loader or test driver and the instruction memory. A small FIFO decouples field submission from memory back-pressure.

## Interface
- `ADDR_WIDTH`, default 10: instruction memory word-address width.
- `FIFO_DEPTH`, default 4: number of packed words buffered; must be a power of 2, ≥2.

Ports (the clock is `clk`; reset is synchronous, active-high, named `reset`):
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: field bundle valid.
- `in_ready` out 1: encoder can accept a bundle.
- `fmt` in 2: 00 = R, 01 = I, 10 = J, 11 = illegal.
- `op` in 6; `rs`, `rt`, `rd`, `shamt` in 5 each; `funct` in 6; `imm_16` in 16; `address_26` in 26: instruction fields.
- `base_load` in 1, `base_addr` in ADDR_WIDTH: reload the write address.
- `mem_we` out 1: write request to memory.
- `mem_ready` in 1: memory accepts the write this cycle.
- `mem_addr` out ADDR_WIDTH: word address of the current write.
- `mem_wdata` out 32: instruction word.
- `count` out 16: completed writes, saturating.
- `err` out 1: sticky illegal-format flag.

## Operation
- **Accept:** a bundle is accepted on an edge where `in_valid && in_ready`.
- **Ready:** `in_ready = !full && !reset`. There is no pass-through when full, even if a pop occurs in the same cycle.
- **Packing:**
  - R: `{op, rs, rt, rd, shamt, funct}`.
  - I: `{op, rs, rt, imm_16}`.
  - J: `{op, address_26}`.
  - Unused fields are ignored.
- **FIFO:** holds FIFO_DEPTH packed words. A simultaneous push and pop while non-full are both performed, and occupancy is unchanged.
- **Write stage:**
  - `mem_we = !empty`.
  - `mem_wdata` is the FIFO head; `mem_addr` is the write pointer.
  - A write completes on an edge where `mem_we && mem_ready`. On completion: pop, pointer + 1 modulo 2^ADDR_WIDTH (0x3FF → 0x000 at default), and `count` + 1, saturating at 0xFFFF.
- **Base load:**
  - On an edge with `base_load`, the pointer becomes `base_addr`. This overrides the increment from a write completing on the same edge.
  - The FIFO contents are kept; queued words go to the new base.
- **Write hold:** `mem_wdata` and `mem_addr` are stable while `mem_we && !mem_ready`.
- **Reset:**
  - Empties the FIFO, mid-stream included; pending words are discarded.
  - Reset values: `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `count=0`, `err=0`, `in_ready=0` during reset and 1 on the first cycle after.

## Timing
- **Latency:** a bundle accepted at edge N appears on `mem_we`/`mem_wdata` in cycle N+1 if the FIFO was empty. It completes at edge N+1 if `mem_ready=1`.
- **Throughput:** one write per cycle with `mem_ready` held high.
- **Back-pressure:** `in_ready` drops in the cycle after the push that fills the FIFO. It rises in the cycle after the first completed write.
- **Output timing:** all outputs are registered or derived from registered state only. There is no combinational path from `in_valid` to `mem_we`.

## Configuration
- **`ENCODER_ERR_EN` defined:**
  - `fmt=11` is accepted but dropped: no push, no write.
  - `err` sets on the accepting edge and stays set until reset.
- **`ENCODER_ERR_EN` undefined:**
  - `fmt=11` is encoded as NOP `32'h00000000` and written like any other word.
  - `err` is tied to 0.

## Test plan
- **R-type:** reset, then `fmt=00, op=0, rs=1, rt=2, rd=3, shamt=0, funct=0x20`, `mem_ready=1` → `mem_wdata=32'h00221820` at `mem_addr=0`; `count=1`.
- **I then J:**
  - Push I (`op=0x08, rs=9, rt=18, imm_16=0xD8A7`) → `32'h2132D8A7` @0.
  - Then push J (`op=0x02, address_26=26'h2A8E52B`) → `32'h0AA8E52B` @1.
- **Back-pressure:**
  - With `mem_ready=0`, push 4 words → `in_ready=0` after the 4th; `mem_we=1`, and `mem_wdata`/`mem_addr` hold.
  - Then raise `mem_ready` → 4 writes on consecutive cycles @0..3; `in_ready` returns to 1.
- **Wrap:** `base_load` with `base_addr=0x3FF`, then push 2 words → writes @0x3FF then @0x000.
- **Base load vs. completion:** assert `base_load` (`base_addr=0x100`) on the same edge as a completing write @5 → next write @0x100.
- **Illegal and reset:**
  - `fmt=11` → with `ENCODER_ERR_EN` defined: no write and `err=1`; undefined: `32'h0` written, `err=0`.
  - Assert `reset` with 3 words queued → `mem_we=0`, `count=0`, `err=0` next cycle.
